// File: rtl/rr_select_arbiter_pkg.sv
// Shared helpers for the round-robin select arbiter.
package rr_select_arbiter_pkg;

  // Increment with an exact wrap at n, so non-power-of-two sizes never overrun.
  function automatic int unsigned rr_wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_select_arbiter_priority_pick.sv
// Wrap-around first-set search: first req bit at or after ptr, wrapping N-1 -> 0.
module rr_priority_pick #(
  parameter int unsigned N = 9,
  parameter int unsigned m = 4
) (
  input  logic [N-1:0] req,
  input  logic [m-1:0] ptr,
  output logic [m-1:0] idx,
  output logic         found
);

  logic [2*N-1:0] w_rot;
  int unsigned    w_j;

  // Rotating a doubled copy puts the scan start at bit 0.
  assign w_rot = {req, req} >> ptr;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    w_j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && w_rot[k]) begin
        found = 1'b1;
        w_j   = int'(ptr) + k;
        if (w_j >= N) w_j = w_j - N;
        idx   = m'(w_j);
      end
    end
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving an N:1 mux select, with registered grant and
// combinational ack on the sel_valid && out_ready handshake.
module rr_select_arbiter
  import rr_select_arbiter_pkg::*;
#(
  parameter int unsigned N = 9,
  parameter int unsigned m = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [m-1:0] sel,
  output logic         sel_valid,
  input  logic         out_ready,
  output logic [N-1:0] gnt,
  output logic [N-1:0] ack
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       r_state, w_state_nxt;
  logic [m-1:0] r_ptr, w_ptr_nxt;
  logic [m-1:0] r_sel, w_sel_nxt;
  logic [m-1:0] w_ptr_inc;
  logic [m-1:0] w_pick_ptr, w_pick_idx;
  logic [N-1:0] w_pick_req, w_sel_oh;
  logic         w_pick_found, w_hs;

  assign w_hs      = (r_state == GRANT) && out_ready;
  assign w_ptr_inc = m'(rr_wrap_inc(int'(r_sel), N));

  always_comb begin
    w_sel_oh        = '0;
    w_sel_oh[r_sel] = 1'b1;
  end

  // While granting, the current holder is masked so it only wins again
  // (after an idle cycle) when it is the sole requester.
  always_comb begin
    w_pick_req = req;
    w_pick_ptr = r_ptr;
    if (r_state == GRANT) begin
      w_pick_req = req & ~w_sel_oh;
      w_pick_ptr = w_ptr_inc;
    end
  end

  rr_priority_pick #(
    .N(N),
    .m(m)
  ) u_pick (
    .req  (w_pick_req),
    .ptr  (w_pick_ptr),
    .idx  (w_pick_idx),
    .found(w_pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_pick_idx;
        end
      end
      GRANT: begin
        if (w_hs) begin
          w_ptr_nxt = w_ptr_inc;
          if (w_pick_found) w_sel_nxt = w_pick_idx;
          else              w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign sel       = r_sel;
  assign sel_valid = (r_state == GRANT);
  assign gnt       = sel_valid ? w_sel_oh : '0;
  assign ack       = w_hs ? w_sel_oh : '0;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Scoreboard bench for rr_select_arbiter: directed scenarios plus random traffic.
module tb_rr_select_arbiter;

  localparam int N = 9;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         out_ready = 1'b0;
  logic [M-1:0] sel;
  logic         sel_valid;
  logic [N-1:0] gnt, ack;

  rr_select_arbiter #(.N(N), .m(M)) dut (
    .clk(clk), .rst(rst), .req(req), .sel(sel), .sel_valid(sel_valid),
    .out_ready(out_ready), .gnt(gnt), .ack(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic [M-1:0] sel;
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: who holds the grant and where the next scan starts.
  bit m_busy;
  int m_sel;
  int m_ptr;

  bit count_en = 0;
  int ack_cnt[N];

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // One clock: drive inputs, queue the expected outputs, then advance the model.
  task automatic step(input logic r, input logic [N-1:0] q, input logic rdy);
    exp_t e;
    int   nxt;
    rst = r; req = q; out_ready = rdy;
    if (r) begin m_busy = 0; m_ptr = 0; m_sel = 0; end
    e.valid = m_busy;
    e.sel   = M'(m_sel);
    e.gnt   = m_busy ? (N'(1) << m_sel) : '0;
    e.ack   = (m_busy && rdy) ? (N'(1) << m_sel) : '0;
    exp_q.push_back(e);
    #2;
    if (count_en) for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
    @(posedge clk);
    if (!r) begin
      if (!m_busy) begin
        nxt = first_from(q, m_ptr);
        if (nxt >= 0) begin m_busy = 1; m_sel = nxt; end
      end else if (rdy) begin
        m_ptr = (m_sel + 1) % N;
        nxt = first_from(q & ~(N'(1) << m_sel), m_ptr);
        if (nxt >= 0) m_sel = nxt;
        else m_busy = 0;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sel_valid", 32'(sel_valid), 32'(e.valid));
      check("sel",       32'(sel),       32'(e.sel));
      check("gnt",       32'(gnt),       32'(e.gnt));
      check("ack",       32'(ack),       32'(e.ack));
    end
  end

  initial begin
    m_busy = 0; m_sel = 0; m_ptr = 0;
    @(posedge clk); #1;

    // Reset held with all requesting, then release and run the fairness window.
    step(1, 9'h1FF, 1'b1);
    step(1, 9'h1FF, 1'b1);
    step(0, 9'h1FF, 1'b1);
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    count_en = 1;
    for (int i = 0; i < 18; i++) step(0, 9'h1FF, 1'b1);
    count_en = 0;
    for (int i = 0; i < N; i++) check($sformatf("ack_cnt[%0d]", i), 32'(ack_cnt[i]), 32'd2);

    // Wrap: grant 7 alone, then 7 and 0 together.
    step(1, '0, 1'b0);
    step(0, 9'h080, 1'b1);
    step(0, 9'h080, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 9'h081, 1'b1);

    // Backpressure on requester 3 with its req dropped.
    step(0, '0, 1'b1);
    step(0, 9'h008, 1'b0);
    for (int i = 0; i < 5; i++) step(0, '0, 1'b0);
    step(0, '0, 1'b1);
    step(0, '0, 1'b1);

    // Mid-grant reset while 5 waits, then restart from ptr 0.
    step(0, 9'h020, 1'b0);
    step(0, 9'h020, 1'b0);
    step(1, 9'h020, 1'b0);
    step(0, 9'h1FF, 1'b0);
    step(0, 9'h1FF, 1'b1);
    step(0, '0, 1'b1);

    // Sparse and empty.
    for (int i = 0; i < 5; i++) step(0, '0, 1'b1);
    step(0, 9'h100, 1'b1);
    step(0, 9'h100, 1'b1);
    step(0, '0, 1'b1);
    step(0, '0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), N'($urandom), ($urandom_range(0, 3) != 0));

    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
